// File: rtl/sa_skew_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sa_skew_feeder_if : tile-control, operand-input and skewed-output bundle   |
// | Optional stall_cnt port present when SA_FEEDER_STALL_CNT_EN is defined.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface sa_skew_feeder_if #(
   parameter int HPE   = 8,
   parameter int WIDTH = 8,
   parameter int KW    = 16
);
   logic                   start;
   logic [KW-1:0]          k_len;
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH*HPE-1:0]   in_a;
   logic [WIDTH*HPE-1:0]   in_b;
   logic [WIDTH*HPE-1:0]   A1;
   logic [WIDTH*HPE-1:0]   B1;
   logic                   busy;
   logic                   done;
`ifdef SA_FEEDER_STALL_CNT_EN
   logic [KW-1:0]          stall_cnt;

   modport master (
      output start, k_len, in_valid, in_a, in_b,
      input  in_ready, A1, B1, busy, done, stall_cnt
   );

   modport slave (
      input  start, k_len, in_valid, in_a, in_b,
      output in_ready, A1, B1, busy, done, stall_cnt
   );
`else
   modport master (
      output start, k_len, in_valid, in_a, in_b,
      input  in_ready, A1, B1, busy, done
   );

   modport slave (
      input  start, k_len, in_valid, in_a, in_b,
      output in_ready, A1, B1, busy, done
   );
`endif
endinterface
`default_nettype wire

// File: rtl/sa_skew_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sa_skew_feeder : diagonal-skew operand feeder for the systolic array edge  |
// | Optional macro SA_FEEDER_STALL_CNT_EN adds the LOAD stall counter.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sa_skew_feeder #(
   parameter int HPE       = 8,
   parameter int WIDTH     = 8,
   parameter int KW        = 16,
   parameter int DRAIN_CYC = 2*HPE+1
) (
   input  wire logic           CLK,
   input  wire logic           RST,
   sa_skew_feeder_if.slave     bus
);

   localparam int                c_vw         = WIDTH*HPE;
   localparam int                c_cnt_w      = $clog2(DRAIN_CYC+1);
   localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(DRAIN_CYC-1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q;
   logic [KW-1:0]        klen_q;
   logic [KW-1:0]        beat_q;
   logic [c_cnt_w-1:0]   drain_q;
   logic                 busy_q;
   logic                 done_q;

   logic                 w_accept;
   logic                 w_last_beat;
   logic [c_vw-1:0]      stage0_a_d;
   logic [c_vw-1:0]      stage0_b_d;
   logic [c_vw-1:0]      w_a1;
   logic [c_vw-1:0]      w_b1;

   assign w_accept    = (state_q == S_LOAD) && bus.in_valid;
   assign w_last_beat = w_accept && ((beat_q + KW'(1)) == klen_q);

   // Every cycle without an accepted beat pushes zeros, so stalls and drain are MAC-neutral.
   assign stage0_a_d  = w_accept ? bus.in_a : '0;
   assign stage0_b_d  = w_accept ? bus.in_b : '0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         klen_q  <= '0;
         beat_q  <= '0;
         drain_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.k_len != '0) begin
                     klen_q  <= bus.k_len;
                     beat_q  <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_LOAD;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  beat_q <= beat_q + KW'(1);
                  if (w_last_beat) begin
                     drain_q <= '0;
                     state_q <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               if (drain_q == c_drain_last) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  drain_q <= drain_q + c_cnt_w'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Lane i owns i+1 registers: stage 0 plus i skew stages.
   for (genvar gi = 0; gi < HPE; gi++) begin : g_lane
      logic [WIDTH-1:0] a_q [0:gi];
      logic [WIDTH-1:0] b_q [0:gi];

      always_ff @(posedge CLK) begin
         if (RST) begin
            for (int j = 0; j <= gi; j++) begin
               a_q[j] <= '0;
               b_q[j] <= '0;
            end
         end else begin
            a_q[0] <= stage0_a_d[WIDTH*gi +: WIDTH];
            b_q[0] <= stage0_b_d[WIDTH*gi +: WIDTH];
            for (int j = 1; j <= gi; j++) begin
               a_q[j] <= a_q[j-1];
               b_q[j] <= b_q[j-1];
            end
         end
      end

      assign w_a1[WIDTH*gi +: WIDTH] = a_q[gi];
      assign w_b1[WIDTH*gi +: WIDTH] = b_q[gi];
   end

`ifdef SA_FEEDER_STALL_CNT_EN
   logic [KW-1:0] stall_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_q <= '0;
      end else if ((state_q == S_IDLE) && bus.start && (bus.k_len != '0)) begin
         stall_q <= '0;
      end else if ((state_q == S_LOAD) && !bus.in_valid && (stall_q != {KW{1'b1}})) begin
         stall_q <= stall_q + KW'(1);
      end
   end

   assign bus.stall_cnt = stall_q;
`endif

   assign bus.in_ready = (state_q == S_LOAD);
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.A1       = w_a1;
   assign bus.B1       = w_b1;

endmodule
`default_nettype wire
